// File: rtl/program_counter.sv
// ECU program counter with a free-running instruction-step counter.
// Build option PC_TRISTATE_EN: drive ao to high-impedance instead of zero when oe=0.
module program_counter #(
    parameter int                WIDTH        = 16,
    parameter int                STEP_WIDTH   = 3,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      ai,
    input  logic                  lrc,
    input  logic                  ini,
    input  logic                  cub,
    input  logic                  oe,
    output logic [WIDTH-1:0]      ao,
    output logic [STEP_WIDTH-1:0] is
);

    logic [WIDTH-1:0]      pc_q;
    logic [STEP_WIDTH-1:0] step_q;

    // Load beats increment; the step counter is sequenced independently of the PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= RESET_VECTOR;
            step_q <= '0;
        end else begin
            if (lrc)
                pc_q <= ai;
            else if (ini)
                pc_q <= pc_q + WIDTH'(1);

            if (cub)
                step_q <= '0;
            else
                step_q <= step_q + STEP_WIDTH'(1);
        end
    end

    assign is = step_q;

`ifdef PC_TRISTATE_EN
    assign ao = oe ? pc_q : {WIDTH{1'bz}};
`else
    assign ao = oe ? pc_q : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_program_counter.sv
// Table-driven directed vectors plus randomized run against a behavioural PC model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ai  = '0;
    logic        lrc = 1'b0;
    logic        ini = 1'b0;
    logic        cub = 1'b0;
    logic        oe  = 1'b1;
    logic [15:0] ao;
    logic [2:0]  is;

    int total = 0;
    int bad   = 0;

    int m_pc   = 0;
    int m_step = 0;

    program_counter dut (
        .clk (clk),
        .rst (rst),
        .ai  (ai),
        .lrc (lrc),
        .ini (ini),
        .cub (cub),
        .oe  (oe),
        .ao  (ao),
        .is  (is)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        lrc;
        logic        ini;
        logic        cub;
        logic        oe;
        logic [15:0] ai;
        logic [15:0] exp_ao;
        logic [2:0]  exp_is;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic l, input logic i,
                                input logic c, input logic o, input logic [15:0] a,
                                input logic [15:0] eao, input logic [2:0] eis);
        vec_t v;
        v.rst = r; v.lrc = l; v.ini = i; v.cub = c; v.oe = o; v.ai = a;
        v.exp_ao = eao; v.exp_is = eis;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic from the behavioural rules, one call per edge.
    task automatic model_edge();
        if (!rst) begin
            m_pc   = 0;
            m_step = 0;
        end else begin
            if (lrc)      m_pc = int'(ai);
            else if (ini) m_pc = (m_pc + 1) % 65536;
            m_step = cub ? 0 : (m_step + 1) % 8;
        end
    endtask

    function automatic logic [15:0] model_ao();
        return oe ? 16'(m_pc) : 16'h0000;
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        // rst, lrc, ini, cub, oe, ai, expected ao, expected is
        vecs.push_back(mk(0,0,0,0,1,16'h0000,16'h0000,3'd0)); // reset edge
        vecs.push_back(mk(1,0,0,0,1,16'h0000,16'h0000,3'd1));
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0001,3'd2));
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0002,3'd3));
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0003,3'd4));
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0004,3'd5));
        vecs.push_back(mk(1,0,0,1,1,16'h0000,16'h0004,3'd0)); // cub while is=5
        vecs.push_back(mk(1,0,0,0,1,16'h0000,16'h0004,3'd1));
        vecs.push_back(mk(1,1,0,0,1,16'h800A,16'h800A,3'd2));
        vecs.push_back(mk(1,1,1,0,1,16'h1234,16'h1234,3'd3)); // load wins
        vecs.push_back(mk(1,0,1,0,0,16'h0000,16'h0000,3'd4)); // oe low
        vecs.push_back(mk(1,0,1,0,0,16'h0000,16'h0000,3'd5));
        vecs.push_back(mk(1,0,0,0,1,16'h0000,16'h1236,3'd6));
        vecs.push_back(mk(1,0,0,0,1,16'h0000,16'h1236,3'd7));
        vecs.push_back(mk(1,0,0,1,1,16'h0000,16'h1236,3'd0)); // cub on wrap edge
        vecs.push_back(mk(1,1,0,1,1,16'hFFFF,16'hFFFF,3'd0)); // load + clear together
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0000,3'd1)); // PC wraps
        vecs.push_back(mk(1,0,1,0,1,16'h0000,16'h0001,3'd2));
        vecs.push_back(mk(0,1,1,1,1,16'hBEEF,16'h0000,3'd0)); // reset beats everything
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1,0,0,0,1,16'h0000,16'h0000,3'(k % 8)));

        @(negedge clk);
        foreach (vecs[n]) begin
            rst = vecs[n].rst; lrc = vecs[n].lrc; ini = vecs[n].ini;
            cub = vecs[n].cub; oe  = vecs[n].oe;  ai  = vecs[n].ai;
            clock_edge();
            check16($sformatf("vec%0d_ao", n), ao, vecs[n].exp_ao);
            check3 ($sformatf("vec%0d_is", n), is, vecs[n].exp_is);
        end

        // oe is combinational: no clock between toggle and check.
        rst = 1; lrc = 1; ini = 0; cub = 0; oe = 1; ai = 16'h5A5A;
        clock_edge();
        lrc = 0;
        oe = 0; #1;
        check16("oe_off_now", ao, 16'h0000);
        oe = 1; #1;
        check16("oe_on_now", ao, 16'h5A5A);

        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 31) != 0);
            lrc = ($urandom_range(0, 7) == 0);
            ini = $urandom_range(0, 1) == 1;
            cub = ($urandom_range(0, 5) == 0);
            oe  = ($urandom_range(0, 3) != 0);
            ai  = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ai = 16'hFFFF;
            clock_edge();
            check16($sformatf("rnd%0d_ao", c), ao, model_ao());
            check3 ($sformatf("rnd%0d_is", c), is, 3'(m_step));
            if ($urandom_range(0, 7) == 0) begin
                oe = ~oe; #1;
                check16($sformatf("rnd%0d_oe", c), ao, model_ao());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
